issue_scoreboard: RTL

- Issue controller between decode_unit and the register-file/ALU execute stage.
- Tracks in-flight register writes per architectural register and stalls issue on RAW and WAW hazards.
- Enforces a cap on outstanding instructions and sequences a drain-for-flush handshake.
- Decode output is presented with a valid; this block returns ready and the issue strobe.

---
 rtl/issue_scoreboard_pkg.sv | 17 +
 rtl/issue_scoreboard_if.sv | 28 ++
 rtl/issue_scoreboard_busy_table.sv | 45 ++++
 rtl/issue_scoreboard.sv | 117 +++++++++++
 4 files changed

// File: rtl/issue_scoreboard_pkg.sv
// Shared types and constants for the issue scoreboard slice.
// Optional statistics counters are enabled by the SCOREBOARD_STATS_EN macro.
package issue_pkg;

    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

    typedef enum logic [1:0] {
        SCHED_RUN,
        SCHED_STALL,
        SCHED_DRAIN
    } sched_state_t;

endpackage

// File: rtl/issue_scoreboard_if.sv
// Decode-to-issue handshake plus writeback return path.
// The master side is decode/execute; the slave side is the scoreboard.
interface issue_scoreboard_if;
    import issue_pkg::*;

    logic      dec_valid;
    logic      dec_rd1_en;
    reg_addr_t dec_rd1_addr;
    logic      dec_wr_en;
    reg_addr_t dec_wr_addr;
    logic      issue_ready;
    logic      issue_fire;
    logic      wb_valid;
    reg_addr_t wb_addr;

    modport master (
        output dec_valid, dec_rd1_en, dec_rd1_addr, dec_wr_en, dec_wr_addr,
        output wb_valid, wb_addr,
        input  issue_ready, issue_fire
    );

    modport slave (
        input  dec_valid, dec_rd1_en, dec_rd1_addr, dec_wr_en, dec_wr_addr,
        input  wb_valid, wb_addr,
        output issue_ready, issue_fire
    );

endinterface

// File: rtl/issue_scoreboard_busy_table.sv
// Pending-write bitmap, one bit per architectural register, x0 held at zero.
// Read ports see the writeback-bypassed view so a retiring register is free this cycle.
module busy_table
    import issue_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                set_en_i,
    input  reg_addr_t           set_addr_i,
    input  logic                clr_en_i,
    input  reg_addr_t           clr_addr_i,
    input  reg_addr_t           rd1_addr_i,
    input  reg_addr_t           wr_addr_i,
    output logic                rd1_busy_o,
    output logic                wr_busy_o,
    output logic                clr_hit_o,
    output logic [NUM_REGS-1:0] busy_o
);

    logic [NUM_REGS-1:0] busy_q, busy_d, busy_eff;

    always_comb begin
        // NOTE: every variable gets a default before any conditional update, so no latch is inferred.
        busy_eff = busy_q;
        if (clr_en_i) busy_eff[clr_addr_i] = 1'b0;
        busy_d = busy_eff;
        // Set is applied after clear, so a same-register set and clear resolves to set.
        if (set_en_i) busy_d[set_addr_i] = 1'b1;
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    assign rd1_busy_o = busy_eff[rd1_addr_i];
    assign wr_busy_o  = busy_eff[wr_addr_i];
    assign clr_hit_o  = busy_q[clr_addr_i];
    assign busy_o     = busy_q;

endmodule

// File: rtl/issue_scoreboard.sv
// Issue controller: RAW/WAW hazard stall, in-flight cap and flush drain sequencing.
// Define SCOREBOARD_STATS_EN to add the stall_cycles/raw_stalls counters.
module issue_scoreboard
    import issue_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 4
) (
    input  logic                clk,
    input  logic                reset,
    issue_scoreboard_if.slave   bus,
    input  logic                flush_req,
    output logic                flush_done,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [CNT_W-1:0]    inflight,
    output logic                wb_err
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [31:0]         stall_cycles,
    output logic [15:0]         raw_stalls
`endif
);

    sched_state_t     state_q;
    logic [CNT_W-1:0] inflight_q;
    logic             wb_err_q, flush_done_q;
    logic             rd1_busy, wr_busy, wb_hit;
    logic             raw, waw, full, flush_go, ready, fire;
    logic             wb_unowned, wb_underflow;

    busy_table #(.NUM_REGS(NUM_REGS)) u_busy (
        .clk        (clk),
        .reset      (reset),
        .set_en_i   (fire && bus.dec_wr_en && bus.dec_wr_addr != REG_ZERO),
        .set_addr_i (bus.dec_wr_addr),
        .clr_en_i   (bus.wb_valid && bus.wb_addr != REG_ZERO),
        .clr_addr_i (bus.wb_addr),
        .rd1_addr_i (bus.dec_rd1_addr),
        .wr_addr_i  (bus.dec_wr_addr),
        .rd1_busy_o (rd1_busy),
        .wr_busy_o  (wr_busy),
        .clr_hit_o  (wb_hit),
        .busy_o     (busy_vec)
    );

    assign raw  = bus.dec_rd1_en && bus.dec_rd1_addr != REG_ZERO && rd1_busy;
    assign waw  = bus.dec_wr_en  && bus.dec_wr_addr  != REG_ZERO && wr_busy;
    assign full = (inflight_q == CNT_W'(MAX_INFLIGHT)) && !bus.wb_valid;

    // The flush_done cycle still sees flush_req high; it must not re-enter drain.
    assign flush_go = flush_req && !flush_done_q;

    assign ready = (state_q != SCHED_DRAIN) && !flush_go && !raw && !waw && !full && !reset;
    assign fire  = bus.dec_valid && ready;

    assign wb_unowned   = bus.wb_valid && bus.wb_addr != REG_ZERO && !wb_hit;
    assign wb_underflow = bus.wb_valid && !fire && inflight_q == '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SCHED_RUN;
            inflight_q   <= '0;
            wb_err_q     <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;
            wb_err_q     <= wb_err_q || wb_unowned || wb_underflow;

            if (fire && !bus.wb_valid)                        inflight_q <= inflight_q + 1'b1;
            else if (!fire && bus.wb_valid && inflight_q != '0) inflight_q <= inflight_q - 1'b1;

            unique case (state_q)
                SCHED_RUN: begin
                    if (flush_go)                   state_q <= SCHED_DRAIN;
                    else if (bus.dec_valid && !ready) state_q <= SCHED_STALL;
                end
                SCHED_STALL: begin
                    if (flush_go)                   state_q <= SCHED_DRAIN;
                    else if (fire || !bus.dec_valid) state_q <= SCHED_RUN;
                end
                SCHED_DRAIN: begin
                    if (inflight_q == '0 && !bus.wb_valid) begin
                        state_q      <= SCHED_RUN;
                        flush_done_q <= 1'b1;
                    end
                end
                default: state_q <= SCHED_RUN;
            endcase
        end
    end

    assign bus.issue_ready = ready;
    assign bus.issue_fire  = fire;
    assign inflight        = inflight_q;
    assign wb_err          = wb_err_q;
    assign flush_done      = flush_done_q;

`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_q;
    logic [15:0] raw_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            raw_q   <= '0;
        end else begin
            if (bus.dec_valid && !ready && stall_q != '1) stall_q <= stall_q + 1'b1;
            if (raw && raw_q != '1)                       raw_q   <= raw_q + 1'b1;
        end
    end

    assign stall_cycles = stall_q;
    assign raw_stalls   = raw_q;
`endif

endmodule
